// File: rtl/piso_stream_buffer.sv
// Parallel-in/serial-out word buffer with valid/ready on both sides.
// One load captures up to DEPTH words, which are then emitted word 0 first.
module piso_stream_buffer #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 17,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CNT_W-1:0]       in_words,
    input  logic [DEPTH*WIDTH-1:0] data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       data_out,
    output logic                   out_last,
    output logic [CNT_W-1:0]       words_left
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_e;

    logic [DEPTH-1:0][WIDTH-1:0] slot_q, slot_d;
    logic [CNT_W-1:0]            words_left_q, words_left_d;
    logic [CNT_W-1:0]            load_cnt;
    state_e                      state_c;
    logic                        in_fire;
    logic                        out_fire;

    assign state_c    = (words_left_q == '0) ? EMPTY : DRAIN;
    assign out_valid  = (state_c == DRAIN);
    assign out_last   = (words_left_q == ONE_C);
    assign words_left = words_left_q;
    assign data_out   = slot_q[0];

    // Accepting on the final word's beat lets blocks stream with no bubble.
    assign in_ready = !flush && ((state_c == EMPTY) || (out_last && out_ready));
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign load_cnt = ((in_words == '0) || (in_words > DEPTH_C)) ? DEPTH_C : in_words;

    always_comb begin
        slot_d       = slot_q;
        words_left_d = words_left_q;
        if (flush) begin
            slot_d       = '0;
            words_left_d = '0;
        end else if (in_fire) begin
            slot_d       = data_in;
            words_left_d = load_cnt;
        end else begin
            case (state_c)
                EMPTY: ;
                DRAIN: begin
                    if (out_fire) begin
                        // Clearing on the last beat keeps data_out at zero while idle.
                        if (out_last) begin
                            slot_d = '0;
                        end else begin
                            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                                slot_d[i] = slot_q[i+1];
                            end
                            slot_d[DEPTH-1] = '0;
                        end
                        words_left_d = words_left_q - ONE_C;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            words_left_q <= '0;
        end else begin
            slot_q       <= slot_d;
            words_left_q <= words_left_d;
        end
    end

endmodule

// File: tb/tb_piso_stream_buffer.sv
// Directed bench for piso_stream_buffer: drives and samples on the falling edge.
module tb_piso_stream_buffer;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 17;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [CNT_W-1:0]       in_words;
    logic [DEPTH*WIDTH-1:0] data_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       data_out;
    logic                   out_last;
    logic [CNT_W-1:0]       words_left;

    int checks = 0;
    int errors = 0;

    piso_stream_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_words(in_words),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .out_last(out_last), .words_left(words_left)
    );

    always #5 clk = ~clk;

    function automatic logic [DEPTH*WIDTH-1:0] mk_block(input logic [WIDTH-1:0] base);
        logic [DEPTH*WIDTH-1:0] b;
        for (int i = 0; i < int'(DEPTH); i++) b[i*WIDTH +: WIDTH] = base + WIDTH'(i);
        return b;
    endfunction

    // Present a load on the next rising edge, then drop in_valid.
    task automatic do_load(input logic [CNT_W-1:0] n, input logic [WIDTH-1:0] base);
        in_valid = 1'b1;
        in_words = n;
        data_in  = mk_block(base);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_words = '0; data_in = '0; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        @(negedge clk);
        checks++;
        if (words_left !== '0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            data_out !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: wl=%0d ov=%b ol=%b do=%h ir=%b, want 0 0 0 0 1",
                     words_left, out_valid, out_last, data_out, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_block;
        out_ready = 1'b1;
        do_load(CNT_W'(17), 64'd1);
        for (int k = 0; k < 17; k++) begin
            checks++;
            if (data_out !== 64'(k + 1) || out_valid !== 1'b1 ||
                out_last !== (k == 16) || words_left !== CNT_W'(17 - k)) begin
                errors++;
                $display("FAIL full_block[%0d]: do=%h ov=%b ol=%b wl=%0d, want do=%h ov=1 ol=%b wl=%0d",
                         k, data_out, out_valid, out_last, words_left, 64'(k + 1), (k == 16), 17 - k);
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || data_out !== '0 || words_left !== '0) begin
            errors++;
            $display("FAIL full_block_end: ov=%b do=%h wl=%0d, want 0 0 0", out_valid, data_out, words_left);
        end
    endtask

    task automatic test_short_block;
        out_ready = 1'b1;
        do_load(CNT_W'(3), 64'hA0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (data_out !== 64'hA0 + 64'(k) || out_last !== (k == 2) || words_left !== CNT_W'(3 - k)) begin
                errors++;
                $display("FAIL short_block[%0d]: do=%h ol=%b wl=%0d, want do=%h ol=%b wl=%0d",
                         k, data_out, out_last, words_left, 64'hA0 + 64'(k), (k == 2), 3 - k);
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || data_out !== '0 || words_left !== '0) begin
            errors++;
            $display("FAIL short_block_end: ov=%b do=%h wl=%0d, want 0 0 0", out_valid, data_out, words_left);
        end
    endtask

    task automatic test_backpressure;
        logic pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int idx = 0;
        out_ready = 1'b0;
        do_load(CNT_W'(4), 64'h10);
        for (int c = 0; c < 8 && idx < 4; c++) begin
            out_ready = pat[c];
            checks++;
            if (data_out !== 64'h10 + 64'(idx) || out_valid !== 1'b1 || words_left !== CNT_W'(4 - idx)) begin
                errors++;
                $display("FAIL backpressure[%0d]: do=%h ov=%b wl=%0d, want do=%h ov=1 wl=%0d",
                         c, data_out, out_valid, words_left, 64'h10 + 64'(idx), 4 - idx);
            end
            @(negedge clk);
            if (pat[c]) idx++;
        end
        checks++;
        if (idx != 4 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_end: emitted=%0d ov=%b, want 4 0", idx, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        do_load(CNT_W'(2), 64'h100);
        checks++;
        if (data_out !== 64'h100) begin
            errors++;
            $display("FAIL b2b_first: do=%h, want 100", data_out);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_words = CNT_W'(3);
        data_in  = mk_block(64'h200);
        #1;
        checks++;
        if (in_ready !== 1'b1 || data_out !== 64'h101 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_last_beat: ir=%b do=%h ol=%b, want 1 101 1", in_ready, data_out, out_last);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || data_out !== 64'h200 + 64'(k) || words_left !== CNT_W'(3 - k)) begin
                errors++;
                $display("FAIL b2b_second[%0d]: ov=%b do=%h wl=%0d, want 1 %h %0d",
                         k, out_valid, data_out, words_left, 64'h200 + 64'(k), 3 - k);
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: ov=%b, want 0", out_valid);
        end
    endtask

    // use_rst=0 clears with flush, use_rst=1 with rst; a load is offered in the same cycle.
    task automatic test_clear(input bit use_rst);
        out_ready = 1'b1;
        do_load(CNT_W'(17), 64'h300);
        repeat (8) @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (words_left !== CNT_W'(9) || data_out !== 64'h308) begin
            errors++;
            $display("FAIL clear_pre(%0d): wl=%0d do=%h, want 9 308", use_rst, words_left, data_out);
        end
        in_valid = 1'b1;
        in_words = CNT_W'(5);
        data_in  = mk_block(64'h400);
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        #1;
        if (!use_rst) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL flush_in_ready: ir=%b, want 0", in_ready);
            end
        end
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (words_left !== '0 || out_valid !== 1'b0 || data_out !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL clear_post(%0d): wl=%0d ov=%b do=%h ol=%b, want 0 0 0 0",
                     use_rst, words_left, out_valid, data_out, out_last);
        end
        @(negedge clk);
    endtask

    task automatic test_clamp_and_ignore;
        logic [CNT_W-1:0] nvals [2] = '{CNT_W'(0), CNT_W'(20)};
        int emitted;
        for (int t = 0; t < 2; t++) begin
            out_ready = 1'b1;
            do_load(nvals[t], 64'h500);
            checks++;
            if (words_left !== CNT_W'(17)) begin
                errors++;
                $display("FAIL clamp_wl(in_words=%0d): wl=%0d, want 17", nvals[t], words_left);
            end
            emitted = 0;
            for (int c = 0; c < 40 && out_valid; c++) begin
                if (data_out !== 64'h500 + 64'(emitted)) begin
                    checks++;
                    errors++;
                    $display("FAIL clamp_data[%0d]: do=%h, want %h", emitted, data_out, 64'h500 + 64'(emitted));
                end
                emitted++;
                @(negedge clk);
            end
            checks++;
            if (emitted != 17) begin
                errors++;
                $display("FAIL clamp_count(in_words=%0d): emitted=%0d, want 17", nvals[t], emitted);
            end
        end
        out_ready = 1'b0;
        do_load(CNT_W'(17), 64'h600);
        in_valid = 1'b1;
        in_words = CNT_W'(2);
        data_in  = mk_block(64'h700);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ignore_in_ready: ir=%b, want 0", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (words_left !== CNT_W'(17) || data_out !== 64'h600) begin
            errors++;
            $display("FAIL ignore_load: wl=%0d do=%h, want 17 600", words_left, data_out);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 40 && out_valid; c++) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignore_drain: ov=%b, want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_short_block();
        test_backpressure();
        test_back_to_back();
        test_clear(1'b0);
        test_clear(1'b1);
        test_clamp_and_ignore();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
